// File: rtl/soc_bus_pkg.sv
// Shared OBI bus types, widths and the default SoC address map.
// Pure declarations plus a decode helper; no clocked logic.
package soc_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  localparam logic [ADDR_W-1:0] RAM_BASE_DEF    = 32'h1000_0000;
  localparam logic [ADDR_W-1:0] RAM_MASK_DEF    = 32'hFFFF_0000;
  localparam logic [ADDR_W-1:0] PERIPH_BASE_DEF = 32'h2000_0000;
  localparam logic [ADDR_W-1:0] PERIPH_MASK_DEF = 32'hFFF0_0000;
  localparam int                MAX_OUTSTANDING_DEF = 2;

  typedef enum logic [1:0] {
    TGT_RAM,
    TGT_PERIPH,
    TGT_ERR
  } bus_target_e;

  // RAM wins when both regions match; anything unmatched is answered locally with an error.
  function automatic bus_target_e decode_target(
    input logic [ADDR_W-1:0] addr,
    input logic [ADDR_W-1:0] ram_base,
    input logic [ADDR_W-1:0] ram_mask,
    input logic [ADDR_W-1:0] periph_base,
    input logic [ADDR_W-1:0] periph_mask
  );
    if ((addr & ram_mask) == ram_base)       return TGT_RAM;
    if ((addr & periph_mask) == periph_base) return TGT_PERIPH;
    return TGT_ERR;
  endfunction

endpackage

// File: rtl/outstanding_fifo.sv
// In-order queue of bus targets for accepted-but-unanswered requests; push is visible at the head next cycle.
// Push while full and pop while empty are ignored; full/empty come from the registered count.
module outstanding_fifo
  import soc_bus_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  bus_target_e push_id_i,
  input  logic        pop_i,
  output bus_target_e head_o,
  output bus_target_e last_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);

  bus_target_e      mem_q [DEPTH];
  bus_target_e      mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] last_ptr;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  assign full_o   = (count_q == CNT_W'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign last_ptr = (wr_ptr_q == '0) ? PTR_MAX : wr_ptr_q - 1'b1;
  assign head_o   = mem_q[rd_ptr_q];
  assign last_o   = mem_q[last_ptr];

  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_id_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= TGT_RAM;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/data_bus_decoder.sv
// Routes core OBI data requests to RAM, peripherals or a local error responder; request path is combinational.
// Stalls the core (gnt=0, no slave req) when the queue is full or the target differs from the last queued one.
module data_bus_decoder
  import soc_bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RAM_BASE        = RAM_BASE_DEF,
  parameter logic [ADDR_W-1:0] RAM_MASK        = RAM_MASK_DEF,
  parameter logic [ADDR_W-1:0] PERIPH_BASE     = PERIPH_BASE_DEF,
  parameter logic [ADDR_W-1:0] PERIPH_MASK     = PERIPH_MASK_DEF,
  parameter int                MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_req_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  input  logic              data_we_i,
  input  logic [BE_W-1:0]   data_be_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              data_err_o,
  output logic              ram_req_o,
  input  logic              ram_gnt_i,
  input  logic              ram_rvalid_i,
  output logic              ram_we_o,
  output logic [BE_W-1:0]   ram_be_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  input  logic              ram_err_i,
  output logic              periph_req_o,
  input  logic              periph_gnt_i,
  input  logic              periph_rvalid_i,
  output logic              periph_we_o,
  output logic [BE_W-1:0]   periph_be_o,
  output logic [ADDR_W-1:0] periph_addr_o,
  output logic [DATA_W-1:0] periph_wdata_o,
  input  logic [DATA_W-1:0] periph_rdata_i,
  input  logic              periph_err_i
);

  bus_target_e target;
  bus_target_e head_id;
  bus_target_e last_id;
  logic        q_full, q_empty;
  logic        accept_ok;
  logic        pop;

  assign target = decode_target(data_addr_i, RAM_BASE, RAM_MASK, PERIPH_BASE, PERIPH_MASK);

  assign ram_we_o       = data_we_i;
  assign ram_be_o       = data_be_i;
  assign ram_addr_o     = data_addr_i;
  assign ram_wdata_o    = data_wdata_i;
  assign periph_we_o    = data_we_i;
  assign periph_be_o    = data_be_i;
  assign periph_addr_o  = data_addr_i;
  assign periph_wdata_o = data_wdata_i;

  // Same-target rule keeps responses in order without tagging.
  assign accept_ok = !rst && data_req_i && !q_full && (q_empty || target == last_id);

  always_comb begin
    ram_req_o    = 1'b0;
    periph_req_o = 1'b0;
    data_gnt_o   = 1'b0;
    if (accept_ok) begin
      unique case (target)
        TGT_RAM: begin
          ram_req_o  = 1'b1;
          data_gnt_o = ram_gnt_i;
        end
        TGT_PERIPH: begin
          periph_req_o = 1'b1;
          data_gnt_o   = periph_gnt_i;
        end
        default: data_gnt_o = 1'b1;
      endcase
    end
  end

  always_comb begin
    data_rvalid_o = 1'b0;
    data_rdata_o  = '0;
    data_err_o    = 1'b0;
    pop           = 1'b0;
    if (!q_empty) begin
      unique case (head_id)
        TGT_RAM: begin
          data_rvalid_o = ram_rvalid_i;
          data_rdata_o  = ram_rdata_i;
          data_err_o    = ram_err_i;
          pop           = ram_rvalid_i;
        end
        TGT_PERIPH: begin
          data_rvalid_o = periph_rvalid_i;
          data_rdata_o  = periph_rdata_i;
          data_err_o    = periph_err_i;
          pop           = periph_rvalid_i;
        end
        default: begin
          data_rvalid_o = 1'b1;
          data_err_o    = 1'b1;
          pop           = 1'b1;
        end
      endcase
    end
  end

  outstanding_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_outstanding_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (data_gnt_o),
    .push_id_i (target),
    .pop_i     (pop),
    .head_o    (head_id),
    .last_o    (last_id),
    .full_o    (q_full),
    .empty_o   (q_empty)
  );

  // A response from a slave that does not own the queue head is dropped; flag it in simulation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(ram_rvalid_i && (q_empty || head_id != TGT_RAM)))
        else $warning("data_bus_decoder: ram_rvalid_i while RAM is not the queue head");
      assert (!(periph_rvalid_i && (q_empty || head_id != TGT_PERIPH)))
        else $warning("data_bus_decoder: periph_rvalid_i while PERIPH is not the queue head");
    end
  end

endmodule
